// File: rtl/bresolve_pkg.sv
`default_nettype none
// ============================================================================
// Package : bproc_pkg
// Brief   : Shared types and helpers for the branch resolution stage:
//           correction packet bit positions, the queued prediction entry
//           and the packet builder.
// Rev     : 1.0  initial release
// ============================================================================
package bproc_pkg;

  localparam int PKT_W      = 42;
  localparam int PKT_VALID  = 41;
  localparam int PKT_MISP   = 40;
  localparam int PKT_PC_HI  = 39;
  localparam int PKT_PC_LO  = 8;
  localparam int PKT_POS_HI = 7;

  // One in-flight fetch prediction, oldest at the queue head
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] fallthru;
    logic [7:0]  pos;
  } pred_entry_t;

  // Assemble a correction packet; the valid bit is always set so the
  // downstream stage sees every resolved branch, correct or not.
  function automatic logic [PKT_W-1:0] build_packet(
    input logic        misp,
    input logic [31:0] pc,
    input logic [7:0]  pos
  );
    logic [PKT_W-1:0] pkt;
    pkt                      = '0;
    pkt[PKT_VALID]           = 1'b1;
    pkt[PKT_MISP]            = misp;
    pkt[PKT_PC_HI:PKT_PC_LO] = pc;
    pkt[PKT_POS_HI:0]        = pos;
    return pkt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bresolve_if.sv
`default_nettype none
// ============================================================================
// Interface : bresolve_if
// Brief     : Prediction, resolution and correction-packet signals of the
//             branch resolution stage. master = fetch/execute side,
//             slave = bresolve.
// Rev       : 1.0  initial release
// ============================================================================
interface bresolve_if #(
  parameter int DEPTH = 8,
  parameter int PCW   = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic           i_pred_valid;
  logic           o_pred_ready;
  logic           i_pred_taken;
  logic [PCW-1:0] i_pred_target;
  logic [PCW-1:0] i_pred_fallthru;
  logic [7:0]     i_pred_pos;

  logic           i_res_valid;
  logic           o_res_ready;
  logic           i_res_taken;
  logic [PCW-1:0] i_res_target;

  logic           o_fire;
  logic [41:0]    o_data;
  logic           o_flush;
  logic [CW-1:0]  o_occupancy;

  modport master (
    output i_pred_valid, i_pred_taken, i_pred_target, i_pred_fallthru, i_pred_pos,
    output i_res_valid, i_res_taken, i_res_target,
    input  o_pred_ready, o_res_ready, o_fire, o_data, o_flush, o_occupancy
  );

  modport slave (
    input  i_pred_valid, i_pred_taken, i_pred_target, i_pred_fallthru, i_pred_pos,
    input  i_res_valid, i_res_taken, i_res_target,
    output o_pred_ready, o_res_ready, o_fire, o_data, o_flush, o_occupancy
  );
endinterface
`default_nettype wire

// File: rtl/bresolve_queue.sv
`default_nettype none
// ============================================================================
// Module : bpred_queue
// Brief  : Circular FIFO of pending predictions. Push is ignored when full,
//          pop when empty; a synchronous flush empties it and overrides both.
// Rev    : 1.0  initial release
// ============================================================================
module bpred_queue
  import bproc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              i_push,
  input  wire              i_pop,
  input  wire              i_flush,
  input  wire pred_entry_t i_data,
  output pred_entry_t      o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam int            AW           = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL_COUNT = (AW + 1)'(DEPTH);

  pred_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == C_FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally (DEPTH is a power of two); flush returns to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bresolve.sv
`default_nettype none
// ============================================================================
// Module : bresolve
// Brief  : Branch resolution. Queues fetch predictions, matches the head
//          against in-order execute outcomes, emits a registered correction
//          packet per resolved branch and flushes younger predictions on a
//          mispredict.
// Rev    : 1.0  initial release
// ============================================================================
module bresolve
  import bproc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PCW   = 32
) (
  input wire        clk,
  input wire        rst,
  bresolve_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  pred_entry_t    w_push_entry;
  pred_entry_t    w_head;
  logic [CW-1:0]  w_count;
  logic           w_full;
  logic           w_empty;
  logic           w_enq;
  logic           w_deq;
  logic           w_misp;
  logic           w_flush;
  logic [PCW-1:0] w_actual_pc;

  logic           r_fire;
  logic           r_flush;
  logic [PKT_W-1:0] r_data;

  assign w_push_entry = '{taken:    bus.i_pred_taken,
                          target:   bus.i_pred_target,
                          fallthru: bus.i_pred_fallthru,
                          pos:      bus.i_pred_pos};

  // Readiness depends only on stored occupancy, never on same-cycle pops
  assign w_enq = bus.i_pred_valid && !w_full;
  assign w_deq = bus.i_res_valid && !w_empty;

  // Not-taken outcomes compare direction only; taken outcomes also the target
  assign w_actual_pc = bus.i_res_taken ? bus.i_res_target : w_head.fallthru;
  assign w_misp      = (bus.i_res_taken != w_head.taken) ||
                       (bus.i_res_taken && (bus.i_res_target != w_head.target));
  assign w_flush     = w_deq && w_misp;

  // A flush also drops any same-cycle enqueue, which is on the wrong path
  bpred_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_flush (w_flush),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Output stage: strobes last one cycle, packet data holds until replaced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fire  <= 1'b0;
      r_flush <= 1'b0;
      r_data  <= '0;
    end else begin
      r_fire  <= w_deq;
      r_flush <= w_flush;
      if (w_deq) r_data <= build_packet(w_misp, w_actual_pc, w_head.pos);
    end
  end

  assign bus.o_pred_ready = !w_full;
  assign bus.o_res_ready  = !w_empty;
  assign bus.o_fire       = r_fire;
  assign bus.o_flush      = r_flush;
  assign bus.o_data       = r_data;
  assign bus.o_occupancy  = w_count;

endmodule
`default_nettype wire

// File: tb/tb_bresolve.sv
`default_nettype none
// ============================================================================
// Module : tb_bresolve
// Brief  : Self-checking bench for bresolve against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bresolve;
  import bproc_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bresolve_if #(.DEPTH(DEPTH), .PCW(32)) bus ();

  bresolve #(.DEPTH(DEPTH), .PCW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: ordered list of outstanding predictions plus last packet
  pred_entry_t mq[$];
  logic        exp_fire  = 1'b0;
  logic        exp_flush = 1'b0;
  logic [41:0] exp_data  = '0;

  localparam logic [49:0] RESET_VEC = {1'b0, 1'b0, 42'h0, 4'd0, 1'b1, 1'b0};

  function automatic logic [49:0] observed();
    return {bus.o_fire, bus.o_flush, bus.o_data, bus.o_occupancy,
            bus.o_pred_ready, bus.o_res_ready};
  endfunction

  function automatic logic [49:0] expected();
    return {exp_fire, exp_flush, exp_data, CW'(mq.size()),
            1'(mq.size() < DEPTH), 1'(mq.size() != 0)};
  endfunction

  function automatic pred_entry_t mk(input logic t, input logic [31:0] tg,
                                     input logic [31:0] ft, input logic [7:0] p);
    pred_entry_t e;
    e.taken = t; e.target = tg; e.fallthru = ft; e.pos = p;
    return e;
  endfunction

  function automatic pred_entry_t rand_entry();
    return mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 4,
              32'($urandom), 8'($urandom));
  endfunction

  // Drive one cycle and advance the model by the architectural rules
  task automatic apply(input logic pv, input pred_entry_t pe,
                       input logic rv, input logic rt, input logic [31:0] rtg);
    pred_entry_t h;
    logic        misp;
    logic [31:0] pc;
    bit          enq;
    bit          deq;
    enq = pv && (mq.size() < DEPTH);
    deq = rv && (mq.size() > 0);
    bus.i_pred_valid    = pv;
    bus.i_pred_taken    = pe.taken;
    bus.i_pred_target   = pe.target;
    bus.i_pred_fallthru = pe.fallthru;
    bus.i_pred_pos      = pe.pos;
    bus.i_res_valid     = rv;
    bus.i_res_taken     = rt;
    bus.i_res_target    = rtg;
    @(posedge clk);
    #1;
    exp_fire  = deq;
    exp_flush = 1'b0;
    if (deq) begin
      h    = mq.pop_front();
      pc   = rt ? rtg : h.fallthru;
      misp = (rt != h.taken) || (rt && (rtg != h.target));
      exp_data = {1'b1, misp, pc, h.pos};
      if (misp) begin
        mq.delete();
        exp_flush = 1'b1;
        enq = 1'b0;
      end
    end
    if (enq) mq.push_back(pe);
    bus.i_pred_valid = 1'b0;
    bus.i_res_valid  = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (observed() !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=%h", observed(), RESET_VEC);
    end
  endtask

  task automatic test_basic();
    apply(1'b1, mk(1'b1, 32'h1000, 32'h0204, 8'd3), 1'b0, 1'b0, 32'h0);
    vectors++;
    if (observed() !== expected()) begin
      miscompares++;
      $display("FAIL basic_enq got=%h want=%h", observed(), expected());
    end
    apply(1'b0, rand_entry(), 1'b1, 1'b1, 32'h1000);
    // packet: valid=1 | misp=0 | pc=0x00001000 | pos=0x03
    vectors++;
    if ({bus.o_fire, bus.o_flush, bus.o_data} !== {1'b1, 1'b0, 42'h200_0010_0003}) begin
      miscompares++;
      $display("FAIL basic_packet got=%b/%b/%h want=1/0/20000100003",
               bus.o_fire, bus.o_flush, bus.o_data);
    end
    apply(1'b0, rand_entry(), 1'b0, 1'b0, 32'h0);
    vectors++;
    if (observed() !== expected()) begin
      miscompares++;
      $display("FAIL basic_hold got=%h want=%h", observed(), expected());
    end
  endtask

  task automatic test_mispredict();
    apply(1'b1, mk(1'b0, 32'h0, 32'h0208, 8'd5), 1'b0, 1'b0, 32'h0);
    apply(1'b0, rand_entry(), 1'b1, 1'b1, 32'h3000);
    vectors++;
    if ({bus.o_fire, bus.o_flush, bus.o_data, bus.o_occupancy} !==
        {1'b1, 1'b1, 1'b1, 1'b1, 32'h3000, 8'd5, 4'd0}) begin
      miscompares++;
      $display("FAIL misp_packet got fire=%b flush=%b data=%h occ=%0d",
               bus.o_fire, bus.o_flush, bus.o_data, bus.o_occupancy);
    end
  endtask

  task automatic test_full_wrap();
    pred_entry_t e9;
    // offset the pointers so that filling the queue crosses the wrap point
    for (int i = 0; i < 3; i++) apply(1'b1, rand_entry(), 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) apply(1'b0, rand_entry(), 1'b1, mq[0].taken, mq[0].target);
    for (int i = 0; i < DEPTH; i++) apply(1'b1, rand_entry(), 1'b0, 1'b0, 32'h0);
    vectors++;
    if ({bus.o_pred_ready, bus.o_occupancy} !== {1'b0, 4'd8}) begin
      miscompares++;
      $display("FAIL full_ready got ready=%b occ=%0d want ready=0 occ=8",
               bus.o_pred_ready, bus.o_occupancy);
    end
    e9 = rand_entry();
    apply(1'b1, e9, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (observed() !== expected()) begin
      miscompares++;
      $display("FAIL full_hold got=%h want=%h", observed(), expected());
    end
    apply(1'b1, e9, 1'b1, mq[0].taken, mq[0].target);
    vectors++;
    if ((observed() !== expected()) || (bus.o_occupancy !== 4'd7)) begin
      miscompares++;
      $display("FAIL full_pop_no_push got=%h want=%h", observed(), expected());
    end
    apply(1'b1, e9, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b0, rand_entry(), 1'b1, mq[0].taken, mq[0].target);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL wrap_drain[%0d] got=%h want=%h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_flush_discard();
    for (int i = 0; i < 3; i++) apply(1'b1, rand_entry(), 1'b0, 1'b0, 32'h0);
    apply(1'b1, rand_entry(), 1'b1, !mq[0].taken, 32'h0000_5550);
    vectors++;
    if ((observed() !== expected()) ||
        ({bus.o_flush, bus.o_res_ready, bus.o_occupancy} !== {1'b1, 1'b0, 4'd0})) begin
      miscompares++;
      $display("FAIL flush_discard got=%h want=%h", observed(), expected());
    end
    apply(1'b0, rand_entry(), 1'b1, 1'b0, 32'h0);
    vectors++;
    if ((observed() !== expected()) || (bus.o_fire !== 1'b0)) begin
      miscompares++;
      $display("FAIL flush_after got=%h want=%h", observed(), expected());
    end
  endtask

  task automatic test_target_compare();
    apply(1'b1, mk(1'b1, 32'h40, 32'h1111, 8'd7), 1'b0, 1'b0, 32'h0);
    apply(1'b0, rand_entry(), 1'b1, 1'b1, 32'h44);
    vectors++;
    if ({bus.o_flush, bus.o_data} !== {1'b1, 1'b1, 1'b1, 32'h44, 8'd7}) begin
      miscompares++;
      $display("FAIL target_diff got flush=%b data=%h", bus.o_flush, bus.o_data);
    end
    apply(1'b1, mk(1'b0, 32'h80, 32'h1234, 8'd9), 1'b0, 1'b0, 32'h0);
    apply(1'b0, rand_entry(), 1'b1, 1'b0, 32'hDEAD);
    vectors++;
    if ({bus.o_flush, bus.o_data} !== {1'b0, 1'b1, 1'b0, 32'h1234, 8'd9}) begin
      miscompares++;
      $display("FAIL nt_any_target got flush=%b data=%h", bus.o_flush, bus.o_data);
    end
  endtask

  task automatic test_random();
    logic        pv;
    logic        rv;
    logic        rt;
    logic [31:0] rtg;
    for (int n = 0; n < 400; n++) begin
      pv = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 1) == 1);
      if ((mq.size() > 0) && ($urandom_range(0, 3) != 0)) begin
        rt  = mq[0].taken;
        rtg = mq[0].taken ? mq[0].target : 32'($urandom);
      end else begin
        rt  = 1'($urandom_range(0, 1));
        rtg = 32'($urandom_range(0, 7)) << 4;
      end
      apply(pv, rand_entry(), rv, rt, rtg);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL random[%0d] got=%h want=%h", n, observed(), expected());
      end
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    mq.delete();
    exp_fire = 1'b0; exp_flush = 1'b0; exp_data = '0;
    for (int i = 0; i < 5; i++) apply(1'b1, rand_entry(), 1'b0, 1'b0, 32'h0);
    apply(1'b0, rand_entry(), 1'b1, mq[0].taken, mq[0].target);
    vectors++;
    if ({bus.o_fire, bus.o_occupancy} !== {1'b1, 4'd4}) begin
      miscompares++;
      $display("FAIL pre_reset got fire=%b occ=%0d want fire=1 occ=4",
               bus.o_fire, bus.o_occupancy);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (observed() !== RESET_VEC) begin
      miscompares++;
      $display("FAIL async_reset got=%h want=%h", observed(), RESET_VEC);
    end
    mq.delete();
    exp_fire = 1'b0; exp_flush = 1'b0; exp_data = '0;
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, rand_entry(), 1'b1, 1'b1, 32'h40);
    vectors++;
    if ((observed() !== expected()) || (bus.o_fire !== 1'b0)) begin
      miscompares++;
      $display("FAIL post_reset_block got=%h want=%h", observed(), expected());
    end
    apply(1'b1, mk(1'b1, 32'h40, 32'h2000, 8'd1), 1'b0, 1'b0, 32'h0);
    apply(1'b0, rand_entry(), 1'b1, 1'b1, 32'h40);
    vectors++;
    if ((observed() !== expected()) || (bus.o_fire !== 1'b1)) begin
      miscompares++;
      $display("FAIL post_reset_resolve got=%h want=%h", observed(), expected());
    end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.i_pred_valid    = 1'b0;
    bus.i_pred_taken    = 1'b0;
    bus.i_pred_target   = '0;
    bus.i_pred_fallthru = '0;
    bus.i_pred_pos      = '0;
    bus.i_res_valid     = 1'b0;
    bus.i_res_taken     = 1'b0;
    bus.i_res_target    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_mispredict();
    test_full_wrap();
    test_flush_discard();
    test_target_compare();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
